fire_control: RTL
=================

# fire_control

Trigger sequencer that sits directly upstream of the weapons ammo counter. It turns raw pilot trigger presses into single-cycle `fire` pulses, with optional fixed-length bursts and a programmable cooldown between shots. It also issues one-cycle ammo-load requests with a load value, and flags dry-fire and wrong-mode presses. Its `fire`, `loadingAmmo` and `ammo_load` outputs drive the weapons block's fire / load / ammo inputs, and it reads back that block's current ammo count.

## Interface
- `n`, 9, ammo / load-value width
- `BURST_LEN`, 3, shots per burst when `burst_en`=1 (1..15)
- `CW`, 8, cooldown counter width
- `ATTACK`, 4'b0010, mode code in which firing is permitted
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `mode`  in  4  ship mode code
- `trigger`  in  1  pilot trigger, level; only rising edges act
- `burst_en`  in  1  1 = burst of `BURST_LEN`, 0 = single shot; sampled on the accepted edge
- `cooldown`  in  CW  idle cycles added between consecutive shots; sampled on each FIRE→COOL entry
- `ammo`  in  n  current ammo count from the weapons counter
- `reload_req`  in  1  request a reload, level
- `reload_val`  in  n  value to load; sampled in the cycle the load is issued
- `fire`  out  1  one-cycle shot pulse
- `loadingAmmo`  out  1  one-cycle load strobe
- `ammo_load`  out  n  load value, valid while `loadingAmmo`=1, else 0
- `dry_fire`  out  1  one-cycle flag: accepted edge in ATTACK with `ammo`=0
- `mode_err`  out  1  one-cycle flag: trigger edge while `mode`≠ATTACK
- `busy`  out  1  state ≠ IDLE
- `shots`  out  16  saturating count of `fire` pulses since reset

## Operation
- Edge detect:
  - `trig_q` registers `trigger` (reset 0).
  - `edge` = `trigger & ~trig_q`.
  - Edges outside IDLE are dropped and never queued.
- State register `st`, 2 bits: IDLE=0, FIRE=1, COOL=2, RELOAD=3.
- Internal registers:
  - `burst_left`, 4 bits.
  - `cool_cnt`, CW bits.
  - `rl_pend`, 1 bit: set whenever `reload_req`=1, cleared on RELOAD entry.
- IDLE, in priority order:
  - (a) `rl_pend | reload_req` → RELOAD.
  - (b) `edge` & `mode`≠ATTACK → assert `mode_err`, stay IDLE.
  - (c) `edge` & ATTACK & `ammo`=0 → assert `dry_fire`, stay IDLE.
  - (d) `edge` & ATTACK & `ammo`≠0 → FIRE, with `burst_left` = `burst_en` ? `BURST_LEN` : 1.
- FIRE:
  - `fire`=1.
  - `burst_left` decrements by 1.
  - `shots` increments, holding at 16'hFFFF.
  - `cool_cnt` ← `cooldown`.
  - Next state is always COOL.
- COOL:
  - If `mode`≠ATTACK, `burst_left` ← 0 (abort); the cooldown still runs to completion.
  - If `cool_cnt`≠0: decrement, stay in COOL.
  - If `cool_cnt`=0 and `burst_left`≠0 and `ammo`≠0 and `mode`=ATTACK → FIRE.
  - Otherwise → IDLE; any remaining burst is discarded.
- RELOAD:
  - `loadingAmmo`=1, `ammo_load`=`reload_val`, clear `rl_pend`.
  - Next state is always IDLE.
- A reload request arriving in FIRE/COOL is latched in `rl_pend` and serviced on the first IDLE cycle. It preempts a trigger edge in that same cycle; the edge is lost.
- `dry_fire`, `mode_err`, `fire`, `loadingAmmo` and `ammo_load` are decoded from registered state or registered flags, so they are glitch-free.
- Reset values: `st`=IDLE; all outputs 0; `shots`=0; `burst_left`, `cool_cnt`, `rl_pend`, `trig_q` all 0.
- Reset mid-burst aborts at once; no further `fire` is issued.

## Timing
- Edge sampled at rising edge k → `fire` high during cycle k+1.
- `mode_err`/`dry_fire` high during cycle k+1, for one cycle.
- Burst pulse spacing is `cooldown`+2 cycles: FIRE takes 1 cycle, COOL takes `cooldown`+1.
  - `cooldown`=0 → `fire` every 2nd cycle.
- After the last shot, `busy` drops `cooldown`+1 cycles after the `fire` cycle.
- The next edge can be accepted in the first IDLE cycle.
- `reload_req` sampled at edge k in IDLE → `loadingAmmo` high in cycle k+1 → IDLE at k+2.
- `ammo` is read only in IDLE and at COOL exit. COOL always lasts ≥1 cycle, so the weapons counter has updated before the next check.
- Async `rst` forces all outputs to 0 immediately, with no clock needed. Operation resumes on the first edge after deassertion.

## Test plan
- Single shot:
  - Stimulus: `mode`=0010, `ammo`=50, `burst_en`=0, `cooldown`=4, one trigger press.
  - Response: exactly one `fire` pulse, 1 cycle after the edge; `busy` high for 6 cycles; `shots`=1.
- Burst:
  - Stimulus: `burst_en`=1, `BURST_LEN`=3, `cooldown`=2, `ammo`=50.
  - Response: `fire` at cycles k+1, k+5, k+9; `shots`=3; a second press at k+3 is ignored.
- Ammo runout mid-burst:
  - Stimulus: `ammo` driven to 0 after the first pulse.
  - Response: only 1 `fire` pulse; return to IDLE after the cooldown.
  - Follow-up: next press gives `dry_fire`=1 for one cycle and no `fire`.
- Mode errors:
  - Stimulus: `mode`=0001 with a press.
    - Response: `mode_err` pulse, no `fire`.
  - Stimulus: `mode` changed to 0001 during COOL of a 3-shot burst.
    - Response: burst stops after the current cooldown.
- Reload:
  - Stimulus: `reload_req` pulse during COOL, `reload_val`=300.
    - Response: `loadingAmmo`=1 with `ammo_load`=300 in the first IDLE cycle plus 1; a trigger edge in that same IDLE cycle is dropped.
  - Stimulus: `reload_req` in IDLE.
    - Response: `loadingAmmo` in the next cycle.
- Reset:
  - Stimulus: assert `rst` asynchronously mid-burst between clock edges.
  - Response: `fire`, `busy`, `shots` go to 0 immediately; no pulses until a new press after deassertion.
  - Saturation: `shots` holds at FFFF once reached (forced via a long run).

Source files
------------

// File: rtl/fire_control.sv
// Trigger sequencer for the weapons ammo counter: edge-qualified shots, fixed bursts,
// programmable inter-shot cooldown, and one-cycle ammo-load requests.
//   state  | meaning
//   IDLE   | waiting for trigger edge or reload request
//   FIRE   | one-cycle shot pulse, cooldown loaded
//   COOL   | cooldown running; decides next shot of burst
//   RELOAD | one-cycle ammo load strobe
module fire_control #(
  parameter int          n         = 9,
  parameter int          BURST_LEN = 3,
  parameter int          CW        = 8,
  parameter logic [3:0]  ATTACK    = 4'b0010
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    mode,
  input  logic          trigger,
  input  logic          burst_en,
  input  logic [CW-1:0] cooldown,
  input  logic [n-1:0]  ammo,
  input  logic          reload_req,
  input  logic [n-1:0]  reload_val,
  output logic          fire,
  output logic          loadingAmmo,
  output logic [n-1:0]  ammo_load,
  output logic          dry_fire,
  output logic          mode_err,
  output logic          busy,
  output logic [15:0]   shots
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    COOL   = 2'd2,
    RELOAD = 2'd3
  } st_t;

  localparam logic [3:0] BURST_INIT = 4'(BURST_LEN);

  st_t           st;
  logic          trig_q;
  logic [3:0]    burst_left;
  logic [CW-1:0] cool_cnt;
  logic          rl_pend;
  logic [n-1:0]  load_q;
  logic          dry_q;
  logic          merr_q;
  logic          trig_edge;

  assign trig_edge = trigger & ~trig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      trig_q     <= 1'b0;
      burst_left <= 4'd0;
      cool_cnt   <= '0;
      rl_pend    <= 1'b0;
      load_q     <= '0;
      dry_q      <= 1'b0;
      merr_q     <= 1'b0;
      shots      <= 16'd0;
    end else begin
      trig_q <= trigger;
      dry_q  <= 1'b0;
      merr_q <= 1'b0;
      if (reload_req) rl_pend <= 1'b1;

      case (st)
        IDLE: begin
          // a pending reload wins over a same-cycle trigger edge, which is lost
          if (rl_pend | reload_req) begin
            st      <= RELOAD;
            rl_pend <= 1'b0;
            load_q  <= reload_val;
          end else if (trig_edge) begin
            if (mode != ATTACK) begin
              merr_q <= 1'b1;
            end else if (ammo == '0) begin
              dry_q <= 1'b1;
            end else begin
              st         <= FIRE;
              burst_left <= burst_en ? BURST_INIT : 4'd1;
            end
          end
        end

        FIRE: begin
          burst_left <= burst_left - 4'd1;
          if (shots != 16'hFFFF) shots <= shots + 16'd1;
          cool_cnt <= cooldown;
          st       <= COOL;
        end

        COOL: begin
          if (mode != ATTACK) burst_left <= 4'd0;
          if (cool_cnt != '0) begin
            cool_cnt <= cool_cnt - CW'(1);
          end else if (burst_left != 4'd0 && ammo != '0 && mode == ATTACK) begin
            st <= FIRE;
          end else begin
            st         <= IDLE;
            burst_left <= 4'd0;
          end
        end

        RELOAD: begin
          rl_pend <= 1'b0;
          load_q  <= '0;
          st      <= IDLE;
        end

        default: st <= IDLE;
      endcase
    end
  end

  assign fire        = (st == FIRE);
  assign loadingAmmo = (st == RELOAD);
  assign ammo_load   = load_q;
  assign dry_fire    = dry_q;
  assign mode_err    = merr_q;
  assign busy        = (st != IDLE);

endmodule
